noc_packet_arbiter: RTL and testbench

Per-output-port arbiter for the NoC router. It shares one output port between the five input blocks (x_plus, x_minus, y_plus, y_minus, local) using round-robin selection. A grant is locked for a whole packet (wormhole) and released only after the tail flit is accepted downstream. The output block instantiates one copy and uses grant / grant_index to steer its flit mux.

---
 rtl/noc_config_pkg.sv | 16 +
 rtl/noc_round_robin_selector.sv | 46 ++++
 rtl/noc_packet_arbiter.sv | 140 ++++++++++++++
 tb/tb_noc_packet_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_config_pkg.sv
// noc_config_pkg
// Shared router configuration: router port count and the state type used by
// the per-output-port packet arbiter.
package noc_config_pkg;

    // x_plus, x_minus, y_plus, y_minus, local
    localparam int NOC_ROUTER_PORTS = 5;

    // IDLE   : no packet owns the output port
    // LOCKED : one requester owns the port until its tail flit is accepted
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } noc_arbiter_state;

endpackage

// File: rtl/noc_round_robin_selector.sv
// noc_round_robin_selector
// Purely combinational round-robin pick: returns the first set request bit at
// or after rr_pointer, wrapping modulo REQUESTERS.
// Ports:
//   request     : request vector, bit i = requester i wants the port
//   rr_pointer  : index with highest priority
//   pick        : one-hot selected requester, zero when request == 0
//   pick_index  : encoded pick, zero when request == 0
module noc_round_robin_selector #(
    parameter int REQUESTERS  = 5,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0]  request,
    input  logic [INDEX_WIDTH-1:0] rr_pointer,
    output logic [REQUESTERS-1:0]  pick,
    output logic [INDEX_WIDTH-1:0] pick_index
);

    logic [REQUESTERS-1:0]   high_mask;
    logic [2*REQUESTERS-1:0] double_req;
    logic [2*REQUESTERS-1:0] double_first;

    // Lower half holds only requests at or above the pointer; upper half holds
    // the full vector so requests below the pointer are found after the wrap.
    // Isolating the lowest set bit of the concatenation gives the winner.
    always_comb begin
        high_mask = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            high_mask[i] = (i >= int'(rr_pointer));
        end
    end

    assign double_req   = {request, request & high_mask};
    assign double_first = double_req & (~double_req + (2*REQUESTERS)'(1));
    assign pick         = double_first[REQUESTERS-1:0] | double_first[2*REQUESTERS-1:REQUESTERS];

    always_comb begin
        pick_index = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (pick[i]) begin
                pick_index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter
// Per-output-port wormhole arbiter. Round-robin selects one of REQUESTERS
// input blocks, locks the grant for the whole packet and releases it when the
// tail flit is accepted downstream. On release the next owner is chosen in
// the same cycle, so back-to-back packets see no idle bubble.
//
// Handshake: a flit moves when out_valid && out_ready. out_valid depends only
// on the registered grant and the owner's request; ack[i] is the pop strobe
// for requester i and is only ever high together with out_ready.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   request, tail     : per-requester flit valid and tail qualifier
//   out_ready         : downstream accepts this cycle
//   grant, grant_index: one-hot and encoded owner (zero when idle)
//   out_valid,out_tail: qualified flit valid / tail toward the output
//   ack               : per-requester flit-pop strobe
//   busy              : a packet currently owns the port
//   debug_state       : FSM state
//   debug_rr_pointer  : round-robin pointer
module noc_packet_arbiter
    import noc_config_pkg::*;
#(
    parameter int REQUESTERS  = NOC_ROUTER_PORTS,
    parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQUESTERS-1:0]  request,
    input  logic [REQUESTERS-1:0]  tail,
    input  logic                   out_ready,
    output logic [REQUESTERS-1:0]  grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   out_valid,
    output logic                   out_tail,
    output logic [REQUESTERS-1:0]  ack,
    output logic                   busy,
    output noc_arbiter_state       debug_state,
    output logic [INDEX_WIDTH-1:0] debug_rr_pointer
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUESTERS - 1);

    noc_arbiter_state       state_q, state_d;
    logic [REQUESTERS-1:0]  grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic [REQUESTERS-1:0]  granted_req;
    logic                   release_now;
    logic [INDEX_WIDTH-1:0] next_ptr;
    logic [INDEX_WIDTH-1:0] sel_pointer;
    logic [REQUESTERS-1:0]  sel_pick;
    logic [INDEX_WIDTH-1:0] sel_index;

    // grant_q is zero in IDLE, so masking with it also qualifies by busy.
    assign granted_req = grant_q & request;
    assign out_valid   = (state_q == LOCKED) && (|granted_req);
    assign out_tail    = out_valid && (|(granted_req & tail));
    assign ack         = granted_req & {REQUESTERS{out_ready}};
    assign release_now = out_tail && out_ready;

    assign next_ptr = (index_q == LAST_INDEX) ? '0 : index_q + INDEX_WIDTH'(1);

    // In the release cycle arbitration already uses the advanced pointer, so
    // the outgoing owner sits at lowest priority for its next head.
    assign sel_pointer = (state_q == LOCKED) ? next_ptr : ptr_q;

    noc_round_robin_selector #(
        .REQUESTERS  (REQUESTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_selector (
        .request    (request),
        .rr_pointer (sel_pointer),
        .pick       (sel_pick),
        .pick_index (sel_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|request) begin
                    grant_d = sel_pick;
                    index_d = sel_index;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (|request) begin
                        grant_d = sel_pick;
                        index_d = sel_index;
                    end else begin
                        grant_d = '0;
                        index_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                index_d = '0;
            end
        endcase
    end

    assign grant            = grant_q;
    assign grant_index      = index_q;
    assign busy             = (state_q == LOCKED);
    assign debug_state      = state_q;
    assign debug_rr_pointer = ptr_q;

    a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));

    a_grant_stable_when_locked : assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCKED && !release_now) |=> $stable(grant_q));

    a_ack_needs_ready : assert property (@(posedge clk) (|ack) |-> out_ready);

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// tb_noc_packet_arbiter
// Directed bench for noc_packet_arbiter. A packet-level model (owner index,
// pointer, first-requester-from-pointer search) predicts every output each
// cycle; directed checks pin specific literal values along the scenarios.
module tb_noc_packet_arbiter;
    import noc_config_pkg::*;

    localparam int N  = 5;
    localparam int IW = $clog2(N);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]     request   = '0;
    logic [N-1:0]     tail      = '0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     grant;
    logic [IW-1:0]    grant_index;
    logic             out_valid;
    logic             out_tail;
    logic [N-1:0]     ack;
    logic             busy;
    noc_arbiter_state debug_state;
    logic [IW-1:0]    debug_rr_pointer;

    noc_packet_arbiter #(.REQUESTERS(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .request          (request),
        .tail             (tail),
        .out_ready        (out_ready),
        .grant            (grant),
        .grant_index      (grant_index),
        .out_valid        (out_valid),
        .out_tail         (out_tail),
        .ack              (ack),
        .busy             (busy),
        .debug_state      (debug_state),
        .debug_rr_pointer (debug_rr_pointer)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- packet-level model ----------------
    int m_owner = -1;   // index of the requester owning the port, -1 when idle
    int m_ptr   = 0;

    function automatic int first_from(input int ptr, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    // Scoreboard: compare at the falling edge, then advance the model using
    // the inputs the next rising edge will sample.
    always @(negedge clk) begin
        if (check_en) begin
            logic [N-1:0] exp_grant;
            logic         exp_valid;
            logic         exp_tail;
            exp_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
            exp_valid = (m_owner >= 0) && request[m_owner];
            exp_tail  = exp_valid && tail[m_owner];
            check("model_grant",     32'(grant),            32'(exp_grant));
            check("model_index",     32'(grant_index),      (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_out_valid", 32'(out_valid),        32'(exp_valid));
            check("model_out_tail",  32'(out_tail),         32'(exp_tail));
            check("model_ack",       32'(ack),              32'(exp_valid && out_ready ? exp_grant : '0));
            check("model_busy",      32'(busy),             32'(m_owner >= 0));
            check("model_pointer",   32'(debug_rr_pointer), 32'(m_ptr));
            if (rst) begin
                m_owner = -1;
                m_ptr   = 0;
            end else if (m_owner < 0) begin
                m_owner = first_from(m_ptr, request);
            end else if (exp_tail && out_ready) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = first_from(m_ptr, request);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [N-1:0] req, input logic [N-1:0] tl, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        request   = req;
        tail      = tl;
        out_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        check_en = 1'b1;

        // Test 1: lone single-flit packet from requester 2.
        do_reset();
        drive(1'b0, 5'b00100, 5'b00100, 1'b1);          // selection cycle
        check("t1_reset_grant", 32'(grant), 32'd0);
        check("t1_reset_busy",  32'(busy),  32'd0);
        check("t1_sel_no_ack",  32'(ack),   32'd0);
        drive(1'b0, 5'b00100, 5'b00100, 1'b1);
        check("t1_grant",       32'(grant),       32'b00100);
        check("t1_index",       32'(grant_index), 32'd2);
        check("t1_ack",         32'(ack),         32'b00100);
        drive(1'b0, 5'b00000, 5'b00000, 1'b1);
        check("t1_pointer",     32'(debug_rr_pointer), 32'd3);
        check("t1_bubble",      32'(out_valid),        32'd0);

        // Test 2: all five requesting, two-flit packets, back to back.
        do_reset();
        drive(1'b0, 5'b11111, 5'b00000, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 5'b11111, (k % 2 == 0) ? 5'b11111 : 5'b00000, 1'b1);
            check("t2_order", 32'(grant_index), 32'(((k - 1) / 2) % 5));
            check("t2_busy",  32'(busy),        32'd1);
        end

        // Test 3: 3-flit packet from requester 1, requester 3 arrives mid-packet.
        do_reset();
        drive(1'b0, 5'b00010, 5'b00000, 1'b1);
        drive(1'b0, 5'b00010, 5'b00000, 1'b1);
        check("t3_grant_a", 32'(grant), 32'b00010);
        check("t3_ack_a",   32'(ack),   32'b00010);
        drive(1'b0, 5'b01010, 5'b00000, 1'b0);
        check("t3_grant_b", 32'(grant), 32'b00010);
        check("t3_ack_b",   32'(ack),   32'd0);
        drive(1'b0, 5'b01010, 5'b00000, 1'b1);
        check("t3_grant_c", 32'(grant), 32'b00010);
        drive(1'b0, 5'b01010, 5'b00010, 1'b1);
        check("t3_grant_d", 32'(grant),    32'b00010);
        check("t3_tail",    32'(out_tail), 32'd1);
        drive(1'b0, 5'b01000, 5'b00000, 1'b1);
        check("t3_next",    32'(grant),    32'b01000);

        // Tests 4/5: request gap on requester 4, then wrap-around to 0 and 4.
        do_reset();
        drive(1'b0, 5'b10000, 5'b00000, 1'b1);
        drive(1'b0, 5'b10000, 5'b00000, 1'b1);
        check("t4_grant", 32'(grant), 32'b10000);
        for (int g = 0; g < 2; g++) begin
            drive(1'b0, 5'b00011, 5'b00000, 1'b1);
            check("t4_gap_grant", 32'(grant),     32'b10000);
            check("t4_gap_valid", 32'(out_valid), 32'd0);
        end
        drive(1'b0, 5'b10011, 5'b00000, 1'b1);
        check("t4_resume", 32'(out_valid), 32'd1);
        drive(1'b0, 5'b10001, 5'b10000, 1'b1);
        drive(1'b0, 5'b10001, 5'b00001, 1'b1);
        check("t5_wrap_winner", 32'(grant),            32'b00001);
        check("t5_wrap_ptr",    32'(debug_rr_pointer), 32'd0);
        drive(1'b0, 5'b00000, 5'b00000, 1'b1);
        check("t5_follow",      32'(grant),            32'b10000);
        check("t5_follow_ptr",  32'(debug_rr_pointer), 32'd1);

        // Test 6: reset while requester 2 holds the port.
        do_reset();
        drive(1'b0, 5'b00100, 5'b00000, 1'b1);
        drive(1'b0, 5'b00101, 5'b00000, 1'b1);
        check("t6_locked", 32'(grant), 32'b00100);
        drive(1'b1, 5'b00101, 5'b00000, 1'b1);
        drive(1'b0, 5'b00101, 5'b00000, 1'b1);
        check("t6_reset_grant", 32'(grant),            32'd0);
        check("t6_reset_ptr",   32'(debug_rr_pointer), 32'd0);
        drive(1'b0, 5'b00101, 5'b00000, 1'b1);
        check("t6_after_reset", 32'(grant),            32'b00001);

        drive(1'b0, 5'b00000, 5'b00000, 1'b0);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
